// File: rtl/pwm_gen.sv
// Single-channel PWM generator: edge/centre counting, double-buffered clipped duty,
// cycle-by-cycle current-limit latch, output enable. Optional dead-time via PWM_DEADTIME_EN.
module pwm_gen #(
  parameter int WIDTH    = 8,
  parameter int PWM_MIN  = 3,
  parameter int PWM_MAX  = 251,
  parameter int DEADTIME = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pwmcntce,
  input  logic             pwmldce,
  input  logic [WIDTH-1:0] wrtdata,
  input  logic             centermode,
  input  logic             invertpwm,
  input  logic             enablepwm,
  input  logic             currentlimit,
  output logic [1:0]       pwmout,
  output logic             period_start,
  output logic             climit_flag
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] DUTY_MIN = WIDTH'(PWM_MIN);
  localparam logic [WIDTH-1:0] DUTY_MAX = WIDTH'(PWM_MAX);

  if ((PWM_MAX >= (2**WIDTH) - 1) || (PWM_MIN > PWM_MAX) || (DEADTIME < 1) || (DEADTIME > 255))
  begin : g_bad_params
    $error("pwm_gen: illegal parameter set");
  end

  function automatic logic [WIDTH-1:0] clamp_duty(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] res;
    if (v < DUTY_MIN) begin
      res = DUTY_MIN;
    end else if (v > DUTY_MAX) begin
      res = DUTY_MAX;
    end else begin
      res = v;
    end
    return res;
  endfunction

  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_mode;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic             r_climit;
  logic             r_pwm_se;
  logic             r_period_start;
  logic             r_drive;

  logic [WIDTH-1:0] w_next;
  logic             w_ps_tick;
  logic [WIDTH-1:0] w_duty_src;
  logic             w_climit_next;
  logic             w_pwm_c;
  logic             w_gate;

  // Next count, period-start tick, shadow bypass and latch next-state.
  always_comb begin
    w_next        = CNT_ZERO;
    w_ps_tick     = 1'b0;
    w_duty_src    = r_shadow;
    w_climit_next = r_climit;
    if (r_mode && !r_dir) begin
      w_next = r_count - CNT_ONE;
    end else begin
      w_next = r_count + CNT_ONE;
    end
    w_ps_tick = pwmcntce && (w_next == CNT_ZERO);
    if (pwmldce) begin
      w_duty_src = wrtdata;
    end else begin
      w_duty_src = r_shadow;
    end
    // set dominates both the period-start clear and the disable clear
    if (currentlimit) begin
      w_climit_next = 1'b1;
    end else if (!enablepwm || w_ps_tick) begin
      w_climit_next = 1'b0;
    end else begin
      w_climit_next = r_climit;
    end
  end

  // Up/down counter; mode is latched only when a new period begins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= CNT_ZERO;
      r_dir   <= 1'b1;
      r_mode  <= 1'b0;
    end else if (pwmcntce) begin
      r_count <= w_next;
      if (w_next == CNT_ZERO) begin
        r_dir  <= 1'b1;
        r_mode <= centermode;
      end else if (r_mode && (w_next == CNT_MAX)) begin
        r_dir  <= 1'b0;
      end else begin
        r_dir  <= r_dir;
      end
    end else begin
      r_count <= r_count;
    end
  end

  // Shadow and active duty registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= CNT_ZERO;
      r_active <= DUTY_MIN;
    end else begin
      if (pwmldce) begin
        r_shadow <= wrtdata;
      end else begin
        r_shadow <= r_shadow;
      end
      if (w_ps_tick) begin
        r_active <= clamp_duty(w_duty_src);
      end else begin
        r_active <= r_active;
      end
    end
  end

  // Compare, current-limit latch and period-start pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_climit       <= 1'b0;
      r_pwm_se       <= 1'b0;
      r_period_start <= 1'b0;
      r_drive        <= 1'b0;
    end else begin
      r_climit       <= w_climit_next;
      r_pwm_se       <= (r_count < r_active) && !w_climit_next;
      r_period_start <= w_ps_tick;
      r_drive        <= 1'b1;
    end
  end

  assign w_pwm_c = r_pwm_se ^ invertpwm;

`ifdef PWM_DEADTIME_EN
  localparam logic [7:0] DT_LOAD = 8'(DEADTIME - 1);
  localparam logic [7:0] DT_INIT = 8'(DEADTIME);

  logic       r_pwm_c_d;
  logic [7:0] r_dt_cnt;
  logic       w_edge;

  assign w_edge = w_pwm_c ^ r_pwm_c_d;

  // Dead-time counter; the edge cycle itself is the first blanked cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_c_d <= 1'b0;
      r_dt_cnt  <= DT_INIT;
    end else begin
      r_pwm_c_d <= w_pwm_c;
      if (w_edge) begin
        r_dt_cnt <= DT_LOAD;
      end else if (r_dt_cnt != 8'd0) begin
        r_dt_cnt <= r_dt_cnt - 8'd1;
      end else begin
        r_dt_cnt <= r_dt_cnt;
      end
    end
  end

  assign w_gate = !w_edge && (r_dt_cnt == 8'd0);
`else
  assign w_gate = 1'b1;
`endif

  assign pwmout       = (enablepwm && r_drive && w_gate) ? {~w_pwm_c, w_pwm_c} : 2'b00;
  assign period_start = r_period_start;
  assign climit_flag  = r_climit;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed self-checking bench for pwm_gen (default build, WIDTH=8, clip 3..251).
module tb_pwm_gen;

  logic       clk = 1'b0;
  logic       reset_n, pwmcntce, pwmldce, centermode, invertpwm, enablepwm, currentlimit;
  logic [7:0] wrtdata;
  logic [1:0] pwmout;
  logic       period_start, climit_flag;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  pwm_gen #(.WIDTH(8), .PWM_MIN(3), .PWM_MAX(251), .DEADTIME(7)) dut (
    .clk(clk), .reset_n(reset_n), .pwmcntce(pwmcntce), .pwmldce(pwmldce), .wrtdata(wrtdata),
    .centermode(centermode), .invertpwm(invertpwm), .enablepwm(enablepwm),
    .currentlimit(currentlimit), .pwmout(pwmout), .period_start(period_start),
    .climit_flag(climit_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_ps(output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!period_start && waited < 1200);
  endtask

  // From a period-start sample, run to the next one; optionally write wr_val at sample wr_at.
  task automatic run_period(input int wr_at, input logic [7:0] wr_val,
                            output int high, output int len, output int bad);
    high = 0; len = 0; bad = 0;
    for (int j = 0; j < 1200; j++) begin
      pwmldce = (j == wr_at);
      wrtdata = wr_val;
      tick();
      pwmldce = 1'b0;
      len++;
      if (pwmout[0]) high++;
      if (pwmout[1] !== ~pwmout[0]) bad++;
      if (period_start) break;
    end
  endtask

  task automatic test_reset();
    int w, h, l, b;
    reset_n = 1'b0; pwmcntce = 1'b1; pwmldce = 1'b0; wrtdata = 8'd0; centermode = 1'b0;
    invertpwm = 1'b0; enablepwm = 1'b1; currentlimit = 1'b0;
    repeat (3) tick();
    n_vec++; if (pwmout !== 2'b00) begin n_err++; $display("FAIL reset_pwmout: got %b expected 00", pwmout); end
    n_vec++; if (period_start !== 1'b0) begin n_err++; $display("FAIL reset_ps: got %b expected 0", period_start); end
    n_vec++; if (climit_flag !== 1'b0) begin n_err++; $display("FAIL reset_climit: got %b expected 0", climit_flag); end
    reset_n = 1'b1;
    sync_ps(w);
    n_vec++; if (w !== 256) begin n_err++; $display("FAIL reset_first_ps: got %0d expected 256", w); end
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 3) begin n_err++; $display("FAIL reset_duty: got %0d expected 3", h); end
  endtask

  task automatic test_edge_duty();
    int h, l, b;
    run_period(5, 8'd128, h, l, b);
    n_vec++; if (h !== 3) begin n_err++; $display("FAIL edge_old_duty: got %0d expected 3", h); end
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 128) begin n_err++; $display("FAIL edge_high: got %0d expected 128", h); end
    n_vec++; if (l !== 256) begin n_err++; $display("FAIL edge_period: got %0d expected 256", l); end
    n_vec++; if (b !== 0) begin n_err++; $display("FAIL edge_complement: got %0d expected 0", b); end
  endtask

  task automatic test_clip();
    int h, l, b;
    run_period(5, 8'd0, h, l, b);
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 3) begin n_err++; $display("FAIL clip_low: got %0d expected 3", h); end
    run_period(5, 8'd255, h, l, b);
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 251) begin n_err++; $display("FAIL clip_high: got %0d expected 251", h); end
    n_vec++; if (l !== 256) begin n_err++; $display("FAIL clip_period: got %0d expected 256", l); end
  endtask

  task automatic test_double_buffer();
    int h, l, b;
    run_period(5, 8'd128, h, l, b);
    run_period(50, 8'd200, h, l, b);
    n_vec++; if (h !== 128) begin n_err++; $display("FAIL db_midwrite_hold: got %0d expected 128", h); end
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 200) begin n_err++; $display("FAIL db_midwrite_apply: got %0d expected 200", h); end
    run_period(255, 8'd100, h, l, b);
    n_vec++; if (h !== 200) begin n_err++; $display("FAIL db_bypass_prev: got %0d expected 200", h); end
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 100) begin n_err++; $display("FAIL db_bypass_apply: got %0d expected 100", h); end
  endtask

  task automatic test_centre();
    int h, l, b;
    centermode = 1'b1;
    run_period(5, 8'd64, h, l, b);
    n_vec++; if (l !== 256) begin n_err++; $display("FAIL centre_switch_len: got %0d expected 256", l); end
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 127) begin n_err++; $display("FAIL centre_high: got %0d expected 127", h); end
    n_vec++; if (l !== 510) begin n_err++; $display("FAIL centre_period: got %0d expected 510", l); end
    n_vec++; if (b !== 0) begin n_err++; $display("FAIL centre_complement: got %0d expected 0", b); end
    centermode = 1'b0;
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (l !== 510) begin n_err++; $display("FAIL centre_hold_mode: got %0d expected 510", l); end
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 64 || l !== 256) begin n_err++; $display("FAIL centre_back_edge: got %0d/%0d expected 64/256", h, l); end
  endtask

  task automatic test_climit();
    int h, l, b, fl;
    run_period(5, 8'd128, h, l, b);
    h = 0; fl = 0;
    for (int j = 0; j < 1200; j++) begin
      currentlimit = (j == 10);
      tick();
      currentlimit = 1'b0;
      if (pwmout[0]) h++;
      if (climit_flag) fl++;
      if (period_start) break;
    end
    n_vec++; if (h !== 10) begin n_err++; $display("FAIL climit_high: got %0d expected 10", h); end
    n_vec++; if (fl !== 245) begin n_err++; $display("FAIL climit_flag_len: got %0d expected 245", fl); end
    n_vec++; if (climit_flag !== 1'b0) begin n_err++; $display("FAIL climit_clear: got %b expected 0", climit_flag); end
    for (int j = 0; j < 1200; j++) begin
      currentlimit = (j >= 250);
      tick();
      if (period_start) break;
    end
    n_vec++; if (climit_flag !== 1'b1) begin n_err++; $display("FAIL climit_set_wins: got %b expected 1", climit_flag); end
    h = 0;
    for (int j = 0; j < 1200; j++) begin
      currentlimit = (j < 3);
      tick();
      if (pwmout[0]) h++;
      if (period_start) break;
    end
    currentlimit = 1'b0;
    n_vec++; if (h !== 0) begin n_err++; $display("FAIL climit_held_high: got %0d expected 0", h); end
    n_vec++; if (climit_flag !== 1'b0) begin n_err++; $display("FAIL climit_held_clear: got %b expected 0", climit_flag); end
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 128) begin n_err++; $display("FAIL climit_recover: got %0d expected 128", h); end
  endtask

  task automatic test_enable();
    int h, l, b;
    n_vec++; if (pwmout !== 2'b10) begin n_err++; $display("FAIL en_before: got %b expected 10", pwmout); end
    enablepwm = 1'b0;
    #1;
    n_vec++; if (pwmout !== 2'b00) begin n_err++; $display("FAIL en_comb_off: got %b expected 00", pwmout); end
    enablepwm = 1'b1; currentlimit = 1'b1;
    tick();
    currentlimit = 1'b0;
    n_vec++; if (climit_flag !== 1'b1 || pwmout !== 2'b10) begin n_err++; $display("FAIL en_latch_set: got %b/%b expected 1/10", climit_flag, pwmout); end
    enablepwm = 1'b0;
    tick();
    n_vec++; if (climit_flag !== 1'b0) begin n_err++; $display("FAIL en_latch_clear: got %b expected 0", climit_flag); end
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 0 || l !== 254) begin n_err++; $display("FAIL en_running: got %0d/%0d expected 0/254", h, l); end
    enablepwm = 1'b1;
  endtask

  task automatic test_invert();
    int h, l, b;
    invertpwm = 1'b1;
    #1;
    n_vec++; if (pwmout !== 2'b01) begin n_err++; $display("FAIL inv_comb: got %b expected 01", pwmout); end
    run_period(5, 8'd64, h, l, b);
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 192 || b !== 0) begin n_err++; $display("FAIL inv_high: got %0d/%0d expected 192/0", h, b); end
    invertpwm = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w, h, l, b;
    repeat (20) tick();
    n_vec++; if (pwmout !== 2'b01) begin n_err++; $display("FAIL rst_mid_pre: got %b expected 01", pwmout); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (pwmout !== 2'b00) begin n_err++; $display("FAIL rst_mid_out: got %b expected 00", pwmout); end
    repeat (2) tick();
    reset_n = 1'b1;
    sync_ps(w);
    n_vec++; if (w !== 256) begin n_err++; $display("FAIL rst_mid_restart: got %0d expected 256", w); end
    run_period(-1, 8'd0, h, l, b);
    n_vec++; if (h !== 3) begin n_err++; $display("FAIL rst_mid_duty: got %0d expected 3", h); end
  endtask

  initial begin
    test_reset();
    test_edge_duty();
    test_clip();
    test_double_buffer();
    test_centre();
    test_climit();
    test_enable();
    test_invert();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
